// File: rtl/wb_commit_queue.sv
// Write-back commit queue: buffers formatted MEM/WB results and drains them to the register file.
// Optional build macro WB_X0_SUPPRESS_EN turns head writes to register 0 into non-writing pops.
module wb_commit_queue #(
  parameter int DATA_W = 64,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_reg,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_load_data,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_signed,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              rf_ready,
  output logic [CNT_W-1:0]  commit_cnt
);

  localparam int PW = $clog2(DEPTH);

  // Handshakes: an entry transfers on in_valid && in_ready; a write completes on
  // rf_we && rf_ready. rf_* stay stable while rf_we is high and rf_ready is low.

  typedef struct packed {
    logic              regWrite;
    logic [REG_AW-1:0] rg;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  entry_t        inEntry;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          push;
  logic          pop;
  logic          headValid;
  logic          headWrite;

  function automatic logic [DATA_W-1:0] formatLoad(input logic [DATA_W-1:0] raw,
                                                   input logic [1:0] size,
                                                   input logic sgn);
    logic [63:0] r64;
    logic [63:0] ext;
    r64 = 64'(raw);
    ext = r64;
    case (size)
      2'd0: ext = sgn ? {{56{r64[7]}}, r64[7:0]} : {56'b0, r64[7:0]};
      2'd1: ext = sgn ? {{48{r64[15]}}, r64[15:0]} : {48'b0, r64[15:0]};
      2'd2: ext = sgn ? {{32{r64[31]}}, r64[31:0]} : {32'b0, r64[31:0]};
      default: begin
        // A 32-bit datapath has no doubleword, so size 3 falls back to word.
        if (DATA_W == 32) ext = sgn ? {{32{r64[31]}}, r64[31:0]} : {32'b0, r64[31:0]};
        else ext = r64;
      end
    endcase
    return ext[DATA_W-1:0];
  endfunction

  always_comb begin
    inEntry          = '0;
    inEntry.regWrite = in_reg_write;
    inEntry.rg       = in_reg;
    inEntry.data     = in_mem_to_reg ? formatLoad(in_load_data, in_ld_size, in_ld_signed)
                                     : in_result;
  end

  assign head      = mem[rdPtr];
  assign headValid = (count != '0);
`ifdef WB_X0_SUPPRESS_EN
  assign headWrite = headValid && head.regWrite && (head.rg != '0);
`else
  assign headWrite = headValid && head.regWrite;
`endif

  assign in_ready = (count != (PW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = headValid && (!headWrite || rf_ready);

  assign rf_we    = headWrite && !rst;
  assign rf_waddr = headValid ? head.rg : '0;
  assign rf_wdata = headValid ? head.data : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= inEntry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      commit_cnt <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop && headWrite) commit_cnt <= commit_cnt + 1'b1;
    end
  end

endmodule
